gpu_vram_arbiter: RTL

Arbiter and sequencer for the GPU's single-port text-mode character RAM (40x25 cells). It shares one RAM port between three users: the scanout reader (fixed priority, never stalled), a built-in clear engine (bulk-zeroes all cells on the clear-screen command), and the command-processor write path (cursor writes and backspace writes). It sits between the GPU command decoder and the character RAM; the scanout/font-ROM path reads through it.

---
 rtl/gpu_pkg.sv | 29 ++
 rtl/gpu_vram_arbiter_if.sv | 37 +++
 rtl/gpu_clear_engine.sv | 68 ++++++
 rtl/gpu_vram_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and types for the text-mode GPU.
// Holds the character-grid geometry, the clear-engine state encoding and
// the command codes shared by the command decoder and the VRAM arbiter.
package gpu_pkg;

  localparam int unsigned TXT_COLS   = 40;
  localparam int unsigned TXT_ROWS   = 25;
  localparam int unsigned TXT_CELLS  = TXT_COLS * TXT_ROWS;
  localparam int unsigned TXT_ADDR_W = 10;
  localparam int unsigned TXT_DATA_W = 8;

  // Clear-engine sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Command-processor opcodes
  typedef enum logic [7:0] {
    CMD_PUT        = 8'hC1,
    CMD_BACKSPACE  = 8'hC2,
    CMD_CLEAR      = 8'hC3,
    CMD_SET_CURSOR = 8'hC4,
    CMD_HOME       = 8'hC5,
    CMD_NEWLINE    = 8'hC6
  } cmd_e;

endpackage

// File: rtl/gpu_vram_arbiter_if.sv
// gpu_vram_arbiter_if: bundles the scanout read port, the command write port,
// the clear control and the single-port character RAM port.
//   slave  : the arbiter side (takes requests, drives the RAM port)
//   master : the requester / RAM side
interface gpu_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    output rd_valid, rd_data, wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    input  rd_valid, rd_data, wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/gpu_clear_engine.sv
// gpu_clear_engine: IDLE/CLEAR/DONE sequencer plus cell address counter that
// walks every cell once when started.
//   clk, reset : clock, async active-low reset
//   start      : begin a clear (ignored unless IDLE)
//   grant      : the RAM port performed this cycle's clear write
//   busy       : clear in progress (CLEAR state)
//   done       : one-cycle completion pulse (DONE state)
//   addr       : cell currently being cleared
module gpu_clear_engine
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = TXT_ADDR_W,
  parameter int unsigned CELLS  = TXT_CELLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              grant,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter only advances on a granted write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (grant) begin
          if (cnt_q == ADDR_W'(CELLS - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CLEAR);
  assign done = (state_q == DONE);
  assign addr = cnt_q;

endmodule

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: shares the single-port character RAM between scanout
// reads (highest priority), the clear engine and command writes.
//   clk, reset : clock, async active-low reset
//   bus        : scanout read, command write, clear control and RAM port
// Grant, wr_ready and the RAM port are combinational from inputs and state;
// read data returns one cycle after the request, zeroed for out-of-range cells.
module gpu_vram_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = TXT_ADDR_W,
  parameter int unsigned DATA_W = TXT_DATA_W,
  parameter int unsigned CELLS  = TXT_CELLS
) (
  input  logic               clk,
  input  logic               reset,
  gpu_vram_arbiter_if.slave  bus
);

  logic              clr_grant;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_valid_q, rd_valid_d;
  logic              oor_q, oor_d;

  gpu_clear_engine #(
    .ADDR_W (ADDR_W),
    .CELLS  (CELLS)
  ) u_clear (
    .clk   (clk),
    .reset (reset),
    .start (bus.clr_start),
    .grant (clr_grant),
    .busy  (clr_busy),
    .done  (clr_done),
    .addr  (clr_addr)
  );

  // Fixed-priority grant: scanout > clear > command write
  always_comb begin
    clr_grant     = clr_busy && !bus.rd_req;
    bus.wr_ready  = !bus.rd_req && !clr_busy;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (bus.rd_req) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.rd_addr;
    end else if (clr_busy) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = clr_addr;
    end else if (bus.wr_valid && (bus.wr_addr < ADDR_W'(CELLS))) begin
      // Out-of-range writes are still accepted but never reach the RAM
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.wr_addr;
      bus.ram_wdata = bus.wr_data;
    end
  end

  // Read-return tracking aligned with the RAM's one-cycle read latency
  always_comb begin
    rd_valid_d = bus.rd_req;
    oor_d      = bus.rd_req && (bus.rd_addr >= ADDR_W'(CELLS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      oor_q      <= oor_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (rd_valid_q && !oor_q) ? bus.ram_rdata : '0;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule
